// File: rtl/dma_cmd_arbiter.sv
// Weighted round-robin arbiter that merges the write and read DMA command streams
// onto one registered host command port, with per-direction outstanding credits.
module dma_cmd_arbiter #(
  parameter int unsigned TAGW       = 7,
  parameter int unsigned WR_WEIGHT  = 4,
  parameter int unsigned RD_WEIGHT  = 4,
  parameter int unsigned WR_CREDITS = 32,
  parameter int unsigned RD_CREDITS = 32,
  parameter int unsigned CW         = 6
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            wr_cmd_valid,
  output logic            wr_cmd_ready,
  input  logic [1023:0]   wr_cmd_data,
  input  logic [127:0]    wr_cmd_be,
  input  logic [63:0]     wr_cmd_ea,
  input  logic [TAGW-1:0] wr_cmd_tag,
  input  logic            rd_cmd_valid,
  output logic            rd_cmd_ready,
  input  logic [127:0]    rd_cmd_be,
  input  logic [63:0]     rd_cmd_ea,
  input  logic [TAGW-1:0] rd_cmd_tag,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic            cmd_rd,
  output logic [1023:0]   cmd_data,
  output logic [127:0]    cmd_be,
  output logic [63:0]     cmd_ea,
  output logic [TAGW-1:0] cmd_tag,
  input  logic            wr_resp_valid,
  input  logic            rd_resp_valid,
  output logic [CW-1:0]   wr_outstanding,
  output logic [CW-1:0]   rd_outstanding,
  output logic            idle,
  output logic [1:0]      credit_err
);

  localparam int unsigned MAXW = (WR_WEIGHT > RD_WEIGHT) ? WR_WEIGHT : RD_WEIGHT;
  localparam int unsigned GW   = $clog2(MAXW + 1);
  localparam logic [GW-1:0] WR_W   = GW'(WR_WEIGHT);
  localparam logic [GW-1:0] RD_W   = GW'(RD_WEIGHT);
  localparam logic [CW-1:0] WR_LIM = CW'(WR_CREDITS);
  localparam logic [CW-1:0] RD_LIM = CW'(RD_CREDITS);

  typedef enum logic {OWN_WR = 1'b0, OWN_RD = 1'b1} owner_e;

  owner_e          owner_q, owner_d, grant_own;
  logic [GW-1:0]   gcnt_q, gcnt_d, gbase, ginc;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [1:0]      err_q, err_d;
  logic            cmd_valid_q, cmd_rd_q;
  logic [1023:0]   cmd_data_q;
  logic [127:0]    cmd_be_q;
  logic [63:0]     cmd_ea_q;
  logic [TAGW-1:0] cmd_tag_q;
  logic            load_en, wr_elig, rd_elig, grant_wr, grant_rd;

  assign load_en = !cmd_valid_q || cmd_ready;
  assign wr_elig = wr_cmd_valid && (wr_cnt_q < WR_LIM);
  assign rd_elig = rd_cmd_valid && (rd_cnt_q < RD_LIM);

  // Grant selection and ownership / weight-counter update
  always_comb begin
    owner_d   = owner_q;
    gcnt_d    = gcnt_q;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    grant_own = OWN_WR;
    gbase     = '0;
    ginc      = '0;
    if (load_en) begin
      unique case (owner_q)
        OWN_WR: begin
          if (wr_elig)      grant_wr = 1'b1;
          else if (rd_elig) grant_rd = 1'b1;
        end
        OWN_RD: begin
          if (rd_elig)      grant_rd = 1'b1;
          else if (wr_elig) grant_wr = 1'b1;
        end
        default: ;
      endcase
    end
    if (grant_wr || grant_rd) begin
      grant_own = grant_rd ? OWN_RD : OWN_WR;
      // a grant stolen from the other side starts a fresh run
      gbase = (grant_own == owner_q) ? gcnt_q : '0;
      ginc  = gbase + GW'(1);
      if (ginc == (grant_rd ? RD_W : WR_W)) begin
        owner_d = grant_rd ? OWN_WR : OWN_RD;
        gcnt_d  = '0;
      end else begin
        owner_d = grant_own;
        gcnt_d  = ginc;
      end
    end
  end

  // Outstanding credit counters with sticky underflow flags
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    err_d    = err_q;
    if (grant_wr && !wr_resp_valid) begin
      wr_cnt_d = wr_cnt_q + CW'(1);
    end else if (!grant_wr && wr_resp_valid) begin
      if (wr_cnt_q == '0) err_d[0] = 1'b1;
      else                wr_cnt_d = wr_cnt_q - CW'(1);
    end
    if (grant_rd && !rd_resp_valid) begin
      rd_cnt_d = rd_cnt_q + CW'(1);
    end else if (!grant_rd && rd_resp_valid) begin
      if (rd_cnt_q == '0) err_d[1] = 1'b1;
      else                rd_cnt_d = rd_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q     <= OWN_WR;
      gcnt_q      <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      err_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_rd_q    <= 1'b0;
      cmd_data_q  <= '0;
      cmd_be_q    <= '0;
      cmd_ea_q    <= '0;
      cmd_tag_q   <= '0;
    end else begin
      owner_q  <= owner_d;
      gcnt_q   <= gcnt_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
      if (load_en) begin
        cmd_valid_q <= grant_wr || grant_rd;
        if (grant_wr) begin
          cmd_rd_q   <= 1'b0;
          cmd_data_q <= wr_cmd_data;
          cmd_be_q   <= wr_cmd_be;
          cmd_ea_q   <= wr_cmd_ea;
          cmd_tag_q  <= wr_cmd_tag;
        end else if (grant_rd) begin
          cmd_rd_q   <= 1'b1;
          cmd_data_q <= '0;
          cmd_be_q   <= rd_cmd_be;
          cmd_ea_q   <= rd_cmd_ea;
          cmd_tag_q  <= rd_cmd_tag;
        end
      end
    end
  end

  assign wr_cmd_ready   = grant_wr;
  assign rd_cmd_ready   = grant_rd;
  assign cmd_valid      = cmd_valid_q;
  assign cmd_rd         = cmd_rd_q;
  assign cmd_data       = cmd_data_q;
  assign cmd_be         = cmd_be_q;
  assign cmd_ea         = cmd_ea_q;
  assign cmd_tag        = cmd_tag_q;
  assign wr_outstanding = wr_cnt_q;
  assign rd_outstanding = rd_cnt_q;
  assign credit_err     = err_q;
  assign idle           = (wr_cnt_q == '0) && (rd_cnt_q == '0) && !cmd_valid_q;

endmodule

// File: tb/tb_dma_cmd_arbiter.sv
// Scoreboard bench for dma_cmd_arbiter: hand-ordered expected commands are queued
// by the stimulus and popped by a monitor on every output handshake.
module tb_dma_cmd_arbiter;

  localparam int unsigned TAGW = 7;
  localparam int unsigned CW   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn;
  logic            wr_cmd_valid, wr_cmd_ready, rd_cmd_valid, rd_cmd_ready;
  logic [1023:0]   wr_cmd_data, cmd_data;
  logic [127:0]    wr_cmd_be, rd_cmd_be, cmd_be;
  logic [63:0]     wr_cmd_ea, rd_cmd_ea, cmd_ea;
  logic [TAGW-1:0] wr_cmd_tag, rd_cmd_tag, cmd_tag;
  logic            cmd_valid, cmd_ready, cmd_rd;
  logic            wr_resp_valid, rd_resp_valid, idle;
  logic [CW-1:0]   wr_outstanding, rd_outstanding;
  logic [1:0]      credit_err;

  // second instance with asymmetric weights
  logic            b_wr_v, b_rd_v, b_wr_rdy, b_rd_rdy, b_cmd_valid, b_cmd_rd, b_idle;
  logic [1023:0]   b_cmd_data;
  logic [127:0]    b_cmd_be;
  logic [63:0]     b_cmd_ea;
  logic [TAGW-1:0] b_cmd_tag;
  logic [CW-1:0]   b_wr_out, b_rd_out;
  logic [1:0]      b_err;

  dma_cmd_arbiter dut (
    .clk(clk), .resetn(resetn),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_data(wr_cmd_data),
    .wr_cmd_be(wr_cmd_be), .wr_cmd_ea(wr_cmd_ea), .wr_cmd_tag(wr_cmd_tag),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_be(rd_cmd_be),
    .rd_cmd_ea(rd_cmd_ea), .rd_cmd_tag(rd_cmd_tag),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_data(cmd_data),
    .cmd_be(cmd_be), .cmd_ea(cmd_ea), .cmd_tag(cmd_tag),
    .wr_resp_valid(wr_resp_valid), .rd_resp_valid(rd_resp_valid),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .idle(idle), .credit_err(credit_err)
  );

  dma_cmd_arbiter #(.WR_WEIGHT(1), .RD_WEIGHT(3)) dut_b (
    .clk(clk), .resetn(resetn),
    .wr_cmd_valid(b_wr_v), .wr_cmd_ready(b_wr_rdy), .wr_cmd_data('0),
    .wr_cmd_be('0), .wr_cmd_ea('0), .wr_cmd_tag('0),
    .rd_cmd_valid(b_rd_v), .rd_cmd_ready(b_rd_rdy), .rd_cmd_be('0),
    .rd_cmd_ea('0), .rd_cmd_tag('0),
    .cmd_valid(b_cmd_valid), .cmd_ready(1'b1), .cmd_rd(b_cmd_rd), .cmd_data(b_cmd_data),
    .cmd_be(b_cmd_be), .cmd_ea(b_cmd_ea), .cmd_tag(b_cmd_tag),
    .wr_resp_valid(1'b0), .rd_resp_valid(1'b0),
    .wr_outstanding(b_wr_out), .rd_outstanding(b_rd_out),
    .idle(b_idle), .credit_err(b_err)
  );

  typedef struct {
    bit              rd;
    logic [TAGW-1:0] tag;
    logic [63:0]     ea;
    logic [127:0]    be;
    logic [1023:0]   data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, drop_e;
  int total = 0, bad = 0;
  int wr_n = 0, rd_n = 0, wr_acc = 0, rd_acc = 0;
  int w0, acc0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Command n of one direction; stimulus and expectations both use it
  function automatic exp_t mk(input bit rd, input int n);
    exp_t e;
    logic [31:0] n32;
    n32    = 32'(n);
    e.rd   = rd;
    e.tag  = TAGW'(n);
    e.ea   = (rd ? 64'h2000_0000_0000_0000 : 64'h1000_0000_0000_0000) | 64'(n32);
    e.be   = {4{n32 ^ (rd ? 32'h5A5A_0000 : 32'hA5A5_0000)}};
    e.data = rd ? 1024'(0) : {32{n32 ^ 32'hDEAD_0000}};
    return e;
  endfunction

  task automatic push(input bit rd, input int n);
    exp_q.push_back(mk(rd, n));
  endtask

  task automatic drive_inputs();
    exp_t w, r;
    w = mk(1'b0, wr_n);
    r = mk(1'b1, rd_n);
    wr_cmd_tag = w.tag; wr_cmd_ea = w.ea; wr_cmd_be = w.be; wr_cmd_data = w.data;
    rd_cmd_tag = r.tag; rd_cmd_ea = r.ea; rd_cmd_be = r.be;
  endtask

  // One clock: note accepts mid-cycle, then present the next command of each side
  task automatic step();
    @(negedge clk);
    if (wr_cmd_valid && wr_cmd_ready) begin wr_n++; wr_acc++; end
    if (rd_cmd_valid && rd_cmd_ready) begin rd_n++; rd_acc++; end
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    for (int i = 0; i < 8 && cmd_valid; i++) step();
    chk("drain_done", cmd_valid, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    wr_cmd_valid = 1'b0; rd_cmd_valid = 1'b0; cmd_ready = 1'b0;
    wr_resp_valid = 1'b0; rd_resp_valid = 1'b0; b_wr_v = 1'b0; b_rd_v = 1'b0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Monitor: exclusivity of readies and scoreboard check on each output handshake
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (wr_cmd_ready || rd_cmd_ready)
        chk("ready_excl", 128'(wr_cmd_ready && rd_cmd_ready), 128'(0));
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd: got tag %0h rd %0b expected none", cmd_tag, cmd_rd);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cmd_rd", cmd_rd, mon_e.rd);
          chk("cmd_tag", cmd_tag, mon_e.tag);
          chk("cmd_ea", cmd_ea, mon_e.ea);
          chk("cmd_be", cmd_be, mon_e.be);
          chk("cmd_data_eq", 128'(cmd_data == mon_e.data), 128'(1));
        end
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_cmd_tag", cmd_tag, '0);
    chk("rst_wr_out", wr_outstanding, '0);
    chk("rst_rd_out", rd_outstanding, '0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_credit_err", credit_err, 2'b00);

    // 4/4 weights: W x4, R x4, repeating, one per cycle
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) push(1'b0, wr_n + 4 * k + i);
      for (int i = 0; i < 4; i++) push(1'b1, rd_n + 4 * k + i);
    end
    wr_cmd_valid = 1'b1; rd_cmd_valid = 1'b1; cmd_ready = 1'b1;
    acc0 = wr_acc + rd_acc;
    repeat (16) step();
    wr_cmd_valid = 1'b0; rd_cmd_valid = 1'b0;
    chk("t1_throughput", 128'(wr_acc + rd_acc - acc0), 128'(16));
    drain();
    chk("t1_wr_out", wr_outstanding, 6'd8);
    chk("t1_rd_out", rd_outstanding, 6'd8);
    chk("t1_not_idle", idle, 1'b0);
    chk("t1_q_empty", 128'(exp_q.size()), 128'(0));

    // weights 1/3: W,R,R,R repeating
    do_reset();
    b_wr_v = 1'b1; b_rd_v = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t2_wr_ready", b_wr_rdy, (i % 4) == 0);
      chk("t2_rd_ready", b_rd_rdy, (i % 4) != 0);
      @(posedge clk);
      #1;
    end
    b_wr_v = 1'b0; b_rd_v = 1'b0;

    // write credit limit
    do_reset();
    for (int i = 0; i < 32; i++) push(1'b0, wr_n + i);
    wr_cmd_valid = 1'b1; cmd_ready = 1'b1;
    acc0 = wr_acc;
    repeat (40) step();
    chk("t3_accepts", 128'(wr_acc - acc0), 128'(32));
    chk("t3_wr_out", wr_outstanding, 6'd32);
    chk("t3_ready_low", wr_cmd_ready, 1'b0);
    push(1'b0, wr_n);
    wr_resp_valid = 1'b1;
    step();
    wr_resp_valid = 1'b0;
    repeat (4) step();
    chk("t3_one_more", 128'(wr_acc - acc0), 128'(33));
    chk("t3_wr_out2", wr_outstanding, 6'd32);
    wr_cmd_valid = 1'b0;
    drain();

    // back-pressure hold and release
    do_reset();
    w0 = wr_n;
    for (int i = 0; i < 4; i++) push(1'b0, w0 + i);
    wr_cmd_valid = 1'b1; cmd_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", cmd_valid, 1'b1);
      chk("t4_hold_tag", cmd_tag, TAGW'(w0));
      chk("t4_hold_ea", cmd_ea, 64'h1000_0000_0000_0000 | 64'(w0));
      chk("t4_hold_be", cmd_be, mk(1'b0, w0).be);
      chk("t4_readies", 128'({wr_cmd_ready, rd_cmd_ready}), 128'(0));
    end
    cmd_ready = 1'b1;
    step();
    chk("t4_next_valid", cmd_valid, 1'b1);
    chk("t4_next_tag", cmd_tag, TAGW'(w0 + 1));
    step();
    step();
    wr_cmd_valid = 1'b0;
    drain();

    // read credits: simultaneous grant+response, then underflow
    do_reset();
    for (int i = 0; i < 4; i++) push(1'b1, rd_n + i);
    rd_cmd_valid = 1'b1; cmd_ready = 1'b1;
    repeat (3) step();
    chk("t5_rd_out3", rd_outstanding, 6'd3);
    rd_resp_valid = 1'b1;
    step();
    rd_cmd_valid = 1'b0; rd_resp_valid = 1'b0;
    chk("t5_grant_resp", rd_outstanding, 6'd3);
    drain();
    for (int i = 0; i < 3; i++) begin
      rd_resp_valid = 1'b1;
      step();
      rd_resp_valid = 1'b0;
    end
    chk("t5_rd_out0", rd_outstanding, 6'd0);
    chk("t5_no_err", credit_err, 2'b00);
    rd_resp_valid = 1'b1;
    step();
    rd_resp_valid = 1'b0;
    chk("t5_underflow_err", credit_err, 2'b10);
    chk("t5_rd_stays0", rd_outstanding, 6'd0);
    step();
    chk("t5_err_sticky", credit_err, 2'b10);
    chk("t5_idle", idle, 1'b1);

    // reset with a command pending and credits in use
    do_reset();
    for (int i = 0; i < 4; i++) push(1'b0, wr_n + i);
    push(1'b1, rd_n);
    wr_cmd_valid = 1'b1; cmd_ready = 1'b1;
    repeat (4) step();
    wr_cmd_valid = 1'b0; rd_cmd_valid = 1'b1;
    step();
    rd_cmd_valid = 1'b0; cmd_ready = 1'b0;
    chk("t6_pending", cmd_valid, 1'b1);
    chk("t6_total_out", 128'(wr_outstanding + rd_outstanding), 128'(5));
    resetn = 1'b0;
    #1;
    chk("t6_rst_valid", cmd_valid, 1'b0);
    chk("t6_rst_wr_out", wr_outstanding, 6'd0);
    chk("t6_rst_rd_out", rd_outstanding, 6'd0);
    chk("t6_rst_idle", idle, 1'b1);
    drop_e = exp_q.pop_back();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    push(1'b0, wr_n);
    wr_cmd_valid = 1'b1; rd_cmd_valid = 1'b1; cmd_ready = 1'b1;
    acc0 = wr_acc;
    step();
    wr_cmd_valid = 1'b0; rd_cmd_valid = 1'b0;
    chk("t6_owner_wr", 128'(wr_acc - acc0), 128'(1));
    drain();

    chk("end_q_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_cmd_arbiter.md
Name: dma_cmd_arbiter

Overview:
- Shares one host DMA command port between the write-channel and read-channel command streams of the data bridge.
- Uses weighted round-robin arbitration with per-direction outstanding-command credit limits.
- One registered output stage.
- Sits between the data bridge channels (dma_wr_cmd_* / dma_rd_cmd_*) and the single command encoder.

Parameters:
TAGW, 7, command tag width
WR_WEIGHT, 4, consecutive write grants before ownership passes to read (>=1)
RD_WEIGHT, 4, consecutive read grants before ownership passes to write (>=1)
WR_CREDITS, 32, max outstanding write commands (1..2^CW-1)
RD_CREDITS, 32, max outstanding read commands (1..2^CW-1)
CW, 6, outstanding-counter width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
wr_cmd_valid  in  1  write command request
wr_cmd_ready  out  1  write command accepted
wr_cmd_data  in  1024  write payload
wr_cmd_be  in  128  write byte enables
wr_cmd_ea  in  64  write effective address
wr_cmd_tag  in  TAGW  write tag
rd_cmd_valid  in  1  read command request
rd_cmd_ready  out  1  read command accepted
rd_cmd_be  in  128  read byte enables
rd_cmd_ea  in  64  read effective address
rd_cmd_tag  in  TAGW  read tag
cmd_valid  out  1  shared command valid
cmd_ready  in  1  encoder accepts
cmd_rd  out  1  1=read, 0=write
cmd_data  out  1024  payload (zero for reads)
cmd_be  out  128  byte enables
cmd_ea  out  64  address
cmd_tag  out  TAGW  tag
wr_resp_valid  in  1  one write completion, returns one write credit
rd_resp_valid  in  1  one read completion, returns one read credit
wr_outstanding  out  CW  outstanding write count
rd_outstanding  out  CW  outstanding read count
idle  out  1  no outstanding commands and cmd_valid=0
credit_err  out  2  sticky underflow flags [1]=rd, [0]=wr

Behaviour:
- Reset (async, resetn=0):
  - cmd_valid=0; cmd_rd/data/be/ea/tag=0.
  - Both outstanding counters=0; credit_err=0.
  - owner=OWN_WR; grant counter gcnt=0; idle=1.
- load_en = !cmd_valid || cmd_ready (output register empty or draining this cycle).
- Eligibility:
  - wr_elig = wr_cmd_valid && wr_outstanding < WR_CREDITS.
  - rd_elig = rd_cmd_valid && rd_outstanding < RD_CREDITS.
- States OWN_WR / OWN_RD. On each cycle with load_en:
  - Owner eligible: grant owner.
  - Otherwise, other side eligible: grant other, owner := other, gcnt restarts from 0 before the increment.
  - Neither eligible: no grant, state and gcnt unchanged.
- After a grant: gcnt+1. If this equals the current owner's weight, owner flips and gcnt=0; otherwise gcnt=gcnt+1.
- wr_cmd_ready / rd_cmd_ready are combinational: asserted only in the cycle that side is granted. Never both in the same cycle.
- Output latency and hold:
  - Granted command is loaded into the output registers on the same edge; cmd_valid rises the next cycle (1-cycle latency).
  - Output fields hold stable while cmd_valid && !cmd_ready.
  - Back-to-back throughput is one command per cycle when cmd_ready=1.
- Outstanding counters:
  - Increment on grant (the accept handshake), not on output handshake.
  - Decrement on the resp_valid pulse.
  - Simultaneous grant and response: counter unchanged.
  - Response with counter=0: counter stays 0 and the matching credit_err bit sets (sticky until reset).
- Credit limit: a side at its credit limit is ineligible; the other side may take every slot regardless of weights. Ownership still passes normally once the blocked side becomes eligible again.
- idle = (wr_outstanding==0) && (rd_outstanding==0) && !cmd_valid, registered-output derived.
- Weight of 1: ownership alternates each grant when both sides are eligible.
- Reset asserted mid-transfer: pending output command is dropped and counters cleared. Upstream must also be reset.

Test Plan:
- Both valid continuously, cmd_ready=1, weights 4/4, credits 32 -> cmd_rd sequence 0,0,0,0,1,1,1,1 repeating; one command per cycle after first.
- WR_WEIGHT=1, RD_WEIGHT=3, both valid -> pattern W,R,R,R repeating; wr_cmd_ready and rd_cmd_ready never high together.
- Only write valid, no responses, WR_CREDITS=32 -> exactly 32 accepts, then wr_cmd_ready=0 and wr_outstanding=32. One wr_resp_valid pulse -> exactly one further accept.
- cmd_ready held 0 for 5 cycles with first command loaded -> cmd_ea/tag/be stable, both readies 0. Release -> next command appears in the following cycle.
- Grant and rd_resp_valid in the same cycle with rd_outstanding=3 -> stays 3. rd_resp_valid with rd_outstanding=0 -> credit_err=2'b10, counter 0.
- resetn low for 1 cycle while cmd_valid=1 and outstanding=5 -> immediately cmd_valid=0, counters 0, idle=1, owner OWN_WR.
